// File: rtl/ram_tp_be_32x64_arb.sv
// ram_tp_be_32x64_arb: round-robin write arbiter and stall-bounded read sequencer for a 32x64 two-port bit-enable SRAM
module ram_tp_be_32x64_arb #(
  parameter int ADR_WD    = 5,
  parameter int DAT_WD    = 64,
  parameter int STALL_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req_a_i,
  input  logic [ADR_WD-1:0] wr_adr_a_i,
  input  logic [DAT_WD-1:0] wr_dat_a_i,
  input  logic [DAT_WD-1:0] wr_msk_a_i,
  output logic              wr_ack_a_o,
  input  logic              wr_req_b_i,
  input  logic [ADR_WD-1:0] wr_adr_b_i,
  input  logic [DAT_WD-1:0] wr_dat_b_i,
  input  logic [DAT_WD-1:0] wr_msk_b_i,
  output logic              wr_ack_b_o,
  input  logic              rd_req_i,
  input  logic [ADR_WD-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic [DAT_WD-1:0] ram_wr_ena_o,
  output logic [ADR_WD-1:0] ram_wr_adr_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  output logic [ADR_WD-1:0] ram_rd_adr_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i,
  output logic [7:0]        coll_cnt_o
);
  localparam int SW = $clog2(STALL_MAX + 2);
  logic              rr_q;
  logic [SW-1:0]     stall_q;
  logic              rd_val_q;
  logic [DAT_WD-1:0] hold_q;
  logic [7:0]        coll_q;
  logic              prio, elig_a, elig_b, stall;
  assign prio   = stall_q == SW'(STALL_MAX);
  // once the read has waited long enough, writers to its address step aside
  assign elig_a = rst_n && wr_req_a_i && !(prio && rd_req_i && wr_adr_a_i == rd_adr_i);
  assign elig_b = rst_n && wr_req_b_i && !(prio && rd_req_i && wr_adr_b_i == rd_adr_i);
  assign wr_ack_a_o   = elig_a && (!elig_b || !rr_q);
  assign wr_ack_b_o   = elig_b && (!elig_a || rr_q);
  assign ram_wr_adr_o = wr_ack_b_o ? wr_adr_b_i : wr_adr_a_i;
  assign ram_wr_dat_o = wr_ack_b_o ? wr_dat_b_i : wr_dat_a_i;
  assign ram_wr_ena_o = wr_ack_a_o ? wr_msk_a_i : wr_ack_b_o ? wr_msk_b_i : '0;
  assign stall        = rd_req_i && !prio && |ram_wr_ena_o && ram_wr_adr_o == rd_adr_i;
  assign rd_ack_o     = rst_n && rd_req_i && !stall;
  assign ram_rd_ena_o = rd_ack_o;
  assign ram_rd_adr_o = rd_adr_i;
  assign rd_val_o     = rd_val_q;
  assign rd_dat_o     = rd_val_q ? ram_rd_dat_i : hold_q;
  assign coll_cnt_o   = coll_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      stall_q  <= '0;
      rd_val_q <= 1'b0;
      hold_q   <= '0;
      coll_q   <= '0;
    end else begin
      if (wr_ack_a_o || wr_ack_b_o) rr_q <= wr_ack_a_o;
      stall_q  <= (rd_ack_o || !rd_req_i) ? '0 : stall ? stall_q + 1'b1 : stall_q;
      if (stall && coll_q != 8'hff) coll_q <= coll_q + 8'd1;
      rd_val_q <= rd_ack_o;
      if (rd_val_q) hold_q <= ram_rd_dat_i;
    end
  end
endmodule

// File: tb/tb_ram_tp_be_32x64_arb.sv
// tb_ram_tp_be_32x64_arb: scoreboard bench for the SRAM access controller with a behavioural SRAM
module tb_ram_tp_be_32x64_arb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_req_a = 0, wr_req_b = 0, rd_req = 0;
  logic [4:0]  wr_adr_a = 0, wr_adr_b = 0, rd_adr = 0;
  logic [63:0] wr_dat_a = 0, wr_dat_b = 0, wr_msk_a = 0, wr_msk_b = 0;
  logic        wr_ack_a, wr_ack_b, rd_ack, rd_val, ram_rd_ena;
  logic [63:0] rd_dat, ram_wr_ena, ram_wr_dat, ram_rd_dat;
  logic [4:0]  ram_wr_adr, ram_rd_adr;
  logic [7:0]  coll_cnt;
  logic [63:0] mem [32];
  logic [63:0] sbq [$];
  int total = 0, bad = 0;
  localparam logic [63:0] D  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] MA = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] MB = 64'h0000_FFFF_0000_FFFF;

  ram_tp_be_32x64_arb dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_a_i(wr_req_a), .wr_adr_a_i(wr_adr_a), .wr_dat_a_i(wr_dat_a), .wr_msk_a_i(wr_msk_a), .wr_ack_a_o(wr_ack_a),
    .wr_req_b_i(wr_req_b), .wr_adr_b_i(wr_adr_b), .wr_dat_b_i(wr_dat_b), .wr_msk_b_i(wr_msk_b), .wr_ack_b_o(wr_ack_b),
    .rd_req_i(rd_req), .rd_adr_i(rd_adr), .rd_ack_o(rd_ack), .rd_val_o(rd_val), .rd_dat_o(rd_dat),
    .ram_wr_ena_o(ram_wr_ena), .ram_wr_adr_o(ram_wr_adr), .ram_wr_dat_o(ram_wr_dat),
    .ram_rd_ena_o(ram_rd_ena), .ram_rd_adr_o(ram_rd_adr), .ram_rd_dat_i(ram_rd_dat),
    .coll_cnt_o(coll_cnt)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_rd_ena) ram_rd_dat <= mem[ram_rd_adr];
    mem[ram_wr_adr] <= (mem[ram_wr_adr] & ~ram_wr_ena) | (ram_wr_dat & ram_wr_ena);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drop;
    wr_req_a = 0;
    wr_req_b = 0;
    rd_req   = 0;
  endtask

  always @(negedge clk) if (rd_val) begin
    chk("sb_pop", sbq.size() != 0, 1);
    if (sbq.size() != 0) chk("sb_dat", rd_dat, sbq.pop_front());
  end

  initial begin
    wr_req_a = 1; wr_req_b = 1; rd_req = 1; wr_msk_a = '1; wr_msk_b = '1;
    @(negedge clk);
    chk("rst_acks", {wr_ack_a, wr_ack_b, rd_ack, ram_rd_ena}, 0);
    chk("rst_ena", ram_wr_ena, 0);
    drop;
    step;
    rst_n = 1;
    @(negedge clk);
    chk("idle_out", {wr_ack_a, wr_ack_b, rd_ack, ram_rd_ena, rd_val}, 0);
    chk("idle_ena", ram_wr_ena, 0);
    chk("idle_dat", rd_dat, 0);
    chk("idle_cnt", coll_cnt, 0);
    step;
    wr_adr_a = 5'd1; wr_dat_a = 64'hAAAA_AAAA_AAAA_AAAA; wr_msk_a = MA;
    wr_adr_b = 5'd2; wr_dat_b = 64'h5555_5555_5555_5555; wr_msk_b = MB;
    wr_req_a = 1; wr_req_b = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_a", wr_ack_a, i % 2 == 0);
      chk("rr_b", wr_ack_b, i % 2 == 1);
      chk("rr_ena", ram_wr_ena, i % 2 == 1 ? MB : MA);
      step;
    end
    drop;
    step;
    wr_adr_a = 5'd3; wr_dat_a = D; wr_msk_a = '1; wr_req_a = 1;
    @(negedge clk);
    chk("w3_ack", wr_ack_a, 1);
    chk("w3_ena", ram_wr_ena, '1);
    chk("w3_adr", ram_wr_adr, 3);
    step;
    wr_req_a = 0; rd_req = 1; rd_adr = 5'd3; sbq.push_back(D);
    @(negedge clk);
    chk("r3_ack", rd_ack, 1);
    chk("r3_ena", ram_rd_ena, 1);
    step;
    rd_req = 0;
    @(negedge clk);
    chk("r3_val", rd_val, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      @(negedge clk);
      chk("hold_dat", rd_dat, D);
      chk("hold_val", rd_val, 0);
    end
    step;
    wr_dat_a = '0; wr_msk_a = 64'h0000_0000_FFFF_FFFF; wr_req_a = 1;
    @(negedge clk);
    chk("pm_ack", wr_ack_a, 1);
    step;
    wr_req_a = 0; rd_req = 1; rd_adr = 5'd3; sbq.push_back(64'h0123_4567_0000_0000);
    @(negedge clk);
    chk("pm_rdack", rd_ack, 1);
    step;
    rd_req = 0; wr_adr_a = 5'd5; wr_dat_a = '1; wr_msk_a = '0; wr_req_a = 1;
    @(negedge clk);
    chk("mz_ack", wr_ack_a, 1);
    chk("mz_ena", ram_wr_ena, 0);
    step;
    drop;
    step;
    wr_adr_a = 5'd7; wr_dat_a = 64'hDEAD_BEEF_0000_0007; wr_msk_a = '1; wr_req_a = 1;
    rd_adr = 5'd7; rd_req = 1; sbq.push_back(64'hDEAD_BEEF_0000_0007);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("c4_rdack", rd_ack, i == 2);
      chk("c4_acka", wr_ack_a, i != 2);
      chk("c4_cnt", coll_cnt, i);
      step;
    end
    drop;
    step;
    wr_dat_a = 64'hCAFE_F00D_0000_0007; rd_req = 1; wr_req_a = 1;
    wr_adr_b = 5'd9; wr_dat_b = 64'h9; wr_msk_b = '1;
    sbq.push_back(64'hCAFE_F00D_0000_0007);
    for (int i = 0; i < 3; i++) begin
      wr_req_b = i == 2;
      @(negedge clk);
      chk("c5_rdack", rd_ack, i == 2);
      chk("c5_acka", wr_ack_a, i != 2);
      chk("c5_ackb", wr_ack_b, i == 2);
      chk("c5_cnt", coll_cnt, 2 + i);
      step;
    end
    drop;
    step;
    rd_adr = 5'd3; rd_req = 1; wr_adr_a = 5'd4; wr_msk_a = '1; wr_req_a = 1;
    @(negedge clk);
    chk("r6_ack", rd_ack, 1);
    chk("r6_acka", wr_ack_a, 1);
    chk("r6_cnt", coll_cnt, 4);
    step;
    rst_n = 0;
    drop;
    @(negedge clk);
    chk("rst_val", rd_val, 0);
    chk("rst_cnt", coll_cnt, 0);
    chk("rst_dat", rd_dat, 0);
    step;
    rst_n = 1;
    wr_adr_a = 5'd10; wr_adr_b = 5'd11; wr_req_a = 1; wr_req_b = 1;
    @(negedge clk);
    chk("rst_rr_a", wr_ack_a, 1);
    chk("rst_rr_b", wr_ack_b, 0);
    step;
    drop;
    @(negedge clk);
    chk("sb_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
